// File: rtl/alu_mc.sv
// Purpose: multi-cycle integer ALU; single-cycle logic/arith/shift/compare, iterative MUL/MULH/DIV/DIVU/REM/REMU.
// Latency: accept edge -> out_valid is 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/DIV class (operand independent).
// Backpressure: one op in flight; in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk/rst_n (async active-low); in_valid/in_ready + op/a/b request side;
//        out_valid/out_ready + res/flags response side, flags = {illegal, dz, ovf, carry, zero}.
module alu_mc #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [4:0]       flags
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4, OP_SLL  = 4'h5, OP_SRL  = 4'h6, OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8, OP_SLTU = 4'h9, OP_MUL  = 4'hA, OP_MULH = 4'hB;
  localparam logic [3:0] OP_DIV  = 4'hC, OP_DIVU = 4'hD, OP_REM  = 4'hE, OP_REMU = 4'hF;

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  state_t state, state_nxt;

  logic accept;
  logic is_mul_in, is_div_in, iter_in;
  logic last;

  // latched operation context
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] mc;      // multiplicand (MUL) or divisor magnitude (DIV)
  logic [WIDTH-1:0] hi, lo;  // MUL: product halves; DIV: partial remainder / quotient
  logic [CW-1:0]    cnt;
  logic             neg_q, sa_q, bz_q, mn_q;

  logic [WIDTH-1:0] res_q;
  logic [4:0]       flags_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = iter_in ? S_EXEC : S_DONE;
      S_EXEC: if (last)     state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  assign accept    = in_valid && in_ready;
  assign is_mul_in = (op == OP_MUL) || (op == OP_MULH);
  assign is_div_in = (op[3:2] == 2'b11);
  assign iter_in   = (is_mul_in && MUL_EN) || (is_div_in && DIV_EN);
  assign last      = (cnt == CW'(WIDTH-1));

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   sum, dif;
  logic [CW-1:0]    sh;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ill, sc_ovf, sc_cy;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    dif    = {1'b0, a} - {1'b0, b};
    sh     = b[CW-1:0];
    sc_res = '0;
    sc_ill = 1'b0;
    sc_ovf = 1'b0;
    sc_cy  = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_cy  = sum[WIDTH];
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif[WIDTH-1:0];
        sc_cy  = dif[WIDTH];  // borrow
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLL:  sc_res = a << sh;
      OP_SRL:  sc_res = a >> sh;
      OP_SRA:  sc_res = $signed(a) >>> sh;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
      // MUL/DIV class only lands here when its unit is compiled out
      default: sc_ill = 1'b1;
    endcase
  end

  // ---------------- iterative datapath ----------------
  logic             sgn_in, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    sgn_in = (op != OP_DIVU) && (op != OP_REMU);
    a_neg  = sgn_in && a[WIDTH-1];
    b_neg  = sgn_in && b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
  end

  logic             is_mul_q;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   rem_try;
  logic             fits;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  // One shift-add or restoring-divide step per EXEC cycle.
  always_comb begin
    is_mul_q = (op_q[3:1] == 3'b101);
    add_s    = {1'b0, hi} + {1'b0, (lo[0] ? mc : {WIDTH{1'b0}})};
    rem_try  = {hi, lo[WIDTH-1]};
    fits     = (rem_try >= {1'b0, mc});
    if (is_mul_q) begin
      nxt_hi = add_s[WIDTH:1];
      nxt_lo = {add_s[0], lo[WIDTH-1:1]};
    end else begin
      nxt_hi = fits ? WIDTH'(rem_try - {1'b0, mc}) : rem_try[WIDTH-1:0];
      nxt_lo = {lo[WIDTH-2:0], fits};
    end
  end

  // Sign fix-up applied to the final step's values so the result lands on the last EXEC edge.
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   q_s, r_s, fin_res;
  logic               fin_ovf, fin_dz;

  always_comb begin
    prod_s  = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
    q_s     = neg_q ? -nxt_lo : nxt_lo;
    r_s     = sa_q  ? -nxt_hi : nxt_hi;
    fin_res = '0;
    fin_ovf = 1'b0;
    fin_dz  = 1'b0;
    case (op_q)
      OP_MUL:  fin_res = prod_s[WIDTH-1:0];
      OP_MULH: fin_res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU: begin
        fin_res = bz_q ? {WIDTH{1'b1}} : q_s;
        fin_ovf = mn_q;
        fin_dz  = bz_q;
      end
      default: begin
        fin_res = bz_q ? a_q : r_s;
        fin_dz  = bz_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      mc      <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      bz_q    <= 1'b0;
      mn_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else if (accept) begin
      op_q  <= op;
      a_q   <= a;
      cnt   <= '0;
      hi    <= '0;
      neg_q <= a_neg ^ b_neg;
      sa_q  <= a_neg;
      bz_q  <= (b == '0);
      mn_q  <= (op == OP_DIV) && (a == SMIN) && (b == '1);
      if (is_mul_in) begin
        lo <= b_mag;
        mc <= a_mag;
      end else begin
        lo <= a_mag;
        mc <= b_mag;
      end
      if (!iter_in) begin
        res_q   <= sc_res;
        flags_q <= {sc_ill, 1'b0, sc_ovf, sc_cy, (sc_res == '0)};
      end
    end else if (state == S_EXEC) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt + 1'b1;
      if (last) begin
        res_q   <= fin_res;
        flags_q <= {1'b0, fin_dz, fin_ovf, 1'b0, (fin_res == '0)};
      end
    end
  end

  assign res   = res_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Purpose: self-checking bench for alu_mc (WIDTH=32) against a plain-arithmetic reference model.
// Latency: expects 1 cycle for single-cycle ops, 33 cycles for MUL/DIV class.
// Backpressure: exercises held out_ready=0, busy in_valid, mid-op reset, and a build with units disabled.
module tb_alu_mc;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b, res;
  logic [4:0]   flags;

  logic         in_valid2, in_ready2, out_valid2;
  logic [W-1:0] res2;
  logic [4:0]   flags2;

  int n_chk = 0;
  int n_err = 0;

  alu_mc #(.WIDTH(W), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .flags(flags)
  );

  alu_mc #(.WIDTH(W), .MUL_EN(1'b0), .DIV_EN(1'b0)) dut_nu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .op(op), .a(a), .b(b),
    .out_valid(out_valid2), .out_ready(1'b1), .res(res2), .flags(flags2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit out_of_range(input longint v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  // Reference: {illegal, dz, ovf, carry, zero, res[31:0]}
  function automatic logic [36:0] ref_alu(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    longint t;
    int sh = int'(y % 32);
    logic [W-1:0] r = '0;
    bit dz = 0, ov = 0, cy = 0;
    case (o)
      4'h0: begin t = ux + uy; r = t[31:0]; cy = (t >= 64'sd4294967296); ov = out_of_range(sx + sy); end
      4'h1: begin r = x - y; cy = (x < y); ov = out_of_range(sx - sy); end
      4'h2: r = x & y;
      4'h3: r = x | y;
      4'h4: r = x ^ y;
      4'h5: r = x << sh;
      4'h6: r = x >> sh;
      4'h7: r = 32'($signed(x) >>> sh);
      4'h8: r = (sx < sy) ? 32'd1 : 32'd0;
      4'h9: r = (x < y) ? 32'd1 : 32'd0;
      4'hA: begin t = sx * sy; r = t[31:0]; end
      4'hB: begin t = sx * sy; r = t[63:32]; end
      4'hC: begin
        if (y == 0) begin r = '1; dz = 1; end
        else begin
          t = sx / sy; r = t[31:0];
          ov = (sx == SMIN) && (sy == -1);
        end
      end
      4'hD: begin if (y == 0) begin r = '1; dz = 1; end else r = x / y; end
      4'hE: begin if (y == 0) begin r = x; dz = 1; end else begin t = sx % sy; r = t[31:0]; end end
      default: begin if (y == 0) begin r = x; dz = 1; end else r = x % y; end
    endcase
    return {1'b0, dz, ov, cy, (r == 0), r};
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [4:0] f, output int lat);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (o >= 4'hA) chk("busy_in_ready", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    r = res; f = flags;
  endtask

  task automatic run_check(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] r);
    logic [4:0]  f;
    int          lat;
    logic [36:0] e;
    do_op(o, x, y, r, f, lat);
    e = ref_alu(o, x, y);
    chk($sformatf("op%0h res", o), r, e[31:0]);
    chk($sformatf("op%0h flags", o), f, e[36:32]);
    chk($sformatf("op%0h latency", o), lat, (o >= 4'hA) ? 33 : 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r, held_r, x, y;
    logic [4:0]   f, held_f;
    logic [36:0]  e;
    logic [3:0]   o;
    int           lat;
    logic [3:0]   nu_op [3];
    nu_op[0] = 4'hA; nu_op[1] = 4'hC; nu_op[2] = 4'h0;

    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset res", res, 0);
    chk("reset flags", flags, 0);

    // directed cases
    run_check(4'h0, 32'h7FFFFFFF, 32'h1, r);        chk("ADD literal", r, 32'h80000000);
    run_check(4'h1, 32'h0, 32'h1, r);               chk("SUB literal", r, 32'hFFFFFFFF);
    run_check(4'h7, 32'h80000000, 32'h21, r);       chk("SRA literal", r, 32'hC0000000);
    run_check(4'hB, 32'hFFFFFFFE, 32'h3, r);        chk("MULH literal", r, 32'hFFFFFFFF);
    run_check(4'hA, 32'h00010000, 32'h00010000, r); chk("MUL literal", r, 32'h0);
    run_check(4'hC, 32'h7, 32'h0, r);               chk("DIV0 literal", r, 32'hFFFFFFFF);
    run_check(4'hE, 32'hFFFFFFF9, 32'h2, r);        chk("REM literal", r, 32'hFFFFFFFF);
    run_check(4'hC, 32'h80000000, 32'hFFFFFFFF, r); chk("DIV ovf literal", r, 32'h80000000);
    run_check(4'hE, 32'h80000000, 32'hFFFFFFFF, r);
    run_check(4'hE, 32'hFFFFFFF9, 32'h0, r);
    run_check(4'h8, 32'hFFFFFFFF, 32'h1, r);
    run_check(4'h9, 32'hFFFFFFFF, 32'h1, r);

    // randomized ops
    for (int i = 0; i < 200; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      if ($urandom_range(0, 9) == 0) x = 32'h80000000;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = '1;
        2: y = 32'($urandom_range(1, 40));
        default: y = $urandom;
      endcase
      run_check(o, x, y, r);
    end

    // backpressure: result held, new offers ignored while busy
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(4'h0, 32'd5, 32'd9, held_r, held_f, lat);
    e = ref_alu(4'h0, 32'd5, 32'd9);
    chk("bp res", held_r, e[31:0]);
    chk("bp flags", held_f, e[36:32]);
    @(negedge clk);
    op = 4'h4; a = 32'h0F0F1234; b = 32'hFFFF0000; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp hold res", res, held_r);
      chk("bp hold flags", flags, held_f);
      chk("bp hold in_ready", in_ready, 0);
      chk("bp hold out_valid", out_valid, 1);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = ref_alu(4'h4, 32'h0F0F1234, 32'hFFFF0000);
    chk("bp next out_valid", out_valid, 1);
    chk("bp next res", res, e[31:0]);

    // reset in the middle of a divide
    @(posedge clk); #1;
    @(negedge clk);
    op = 4'hC; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst in_ready", in_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("midrst no result", out_valid, 0);
    chk("midrst res", res, 0);
    run_check(4'h0, 32'h12345678, 32'h11111111, r);

    // build with MUL/DIV units disabled
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("nu in_ready", in_ready2, 1);
      op = nu_op[i]; a = 32'h00000123; b = 32'h00000045; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      e = ref_alu(nu_op[i], 32'h00000123, 32'h00000045);
      chk("nu out_valid", out_valid2, 1);
      chk("nu res", res2, (nu_op[i] >= 4'hA) ? 32'h0 : e[31:0]);
      chk("nu flags", flags2, (nu_op[i] >= 4'hA) ? 5'b10001 : e[36:32]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
